// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling and
// the baud-divider function also used by the transmitter's baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_e;

    localparam int OVERSAMPLE_DEFAULT = 16;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Restartable prescaler: counts 0..DIV-1 and pulses tick on the wrap cycle.
// clear restarts the count so tick phase is fixed relative to the clear edge.
module uart_rx_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled start/data/stop sampling,
// one-cycle rx_valid / rx_frame_err strobes and a busy flag.
import uart_pkg::*;

module uart_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    // Strobe semantics: no backpressure. rx_valid is high for one cycle and
    // rx_data is new in that same cycle; the consumer must take it then.
    // rx_frame_err is an equally short, mutually exclusive strobe.

    logic            rxd_meta;
    logic            rxd_s;
    rx_state_e       state, state_nxt;
    logic [TW-1:0]   tick_cnt, tick_cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shift, shift_nxt;
    logic [7:0]      data_nxt;
    logic            valid_nxt;
    logic            ferr_nxt;
    logic            presc_clr;
    logic            tick;

    uart_rx_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (presc_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_meta     <= 1'b1;
            rxd_s        <= 1'b1;
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rxd_meta     <= rxd;
            rxd_s        <= rxd_meta;
            state        <= state_nxt;
            tick_cnt     <= tick_cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            shift        <= shift_nxt;
            rx_data      <= data_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift;
        data_nxt     = rx_data;
        valid_nxt    = 1'b0;
        ferr_nxt     = 1'b0;
        presc_clr    = 1'b0;

        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_nxt    = START;
                    presc_clr    = 1'b1;
                    tick_cnt_nxt = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_cnt_nxt = '0;
                        bit_idx_nxt  = '0;
                        state_nxt    = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_cnt_nxt = '0;
                        shift_nxt    = {rxd_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state_nxt = STOP;
                        end else begin
                            bit_idx_nxt = bit_idx + 3'd1;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
            end

            // Leaving at mid-stop lets a start bit with no idle gap be caught.
            STOP: begin
                if (tick) begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_cnt_nxt = '0;
                        if (rxd_s) begin
                            data_nxt  = shift;
                            valid_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = WAIT_HI;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
            end

            WAIT_HI: begin
                if (rxd_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule
